// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared widths, stage codes and request/response types for the hazard scoreboard.
package pipe_hazard_scoreboard_pkg;
  localparam int NREGS = 32;
  localparam int RAW   = $clog2(NREGS);
  localparam int DEPTH = 3;
  localparam int SELW  = $clog2(DEPTH + 1);
  localparam int CNTW  = 32;

  localparam logic [SELW-1:0] STG_EX      = SELW'(1);
  localparam logic [SELW-1:0] STG_MEM     = SELW'(2);
  localparam logic [SELW-1:0] STG_WB      = SELW'(3);
  localparam logic [SELW-1:0] FWD_REGFILE = '0;
  localparam logic [SELW-1:0] LAT_ALU     = SELW'(1);
  localparam logic [SELW-1:0] LAT_LOAD    = SELW'(2);

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [RAW-1:0]  rd;
    logic            we;
    logic [SELW-1:0] lat;
  } id_req_t;

  // Out-of-range latencies behave as the slowest unit.
  function automatic logic [SELW-1:0] fix_lat(input logic [SELW-1:0] l);
    return (l == '0 || int'(l) > DEPTH) ? SELW'(DEPTH) : l;
  endfunction
endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side request, pipeline control and scoreboard responses.
interface pipe_hazard_scoreboard_if;
  import pipe_hazard_scoreboard_pkg::*;
  id_req_t         id;
  logic            redirect;
  logic            pipe_hold;
  logic            stall;
  logic            flush_id;
  logic [SELW-1:0] fwd1_sel;
  logic [SELW-1:0] fwd2_sel;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  modport master (output id, redirect, pipe_hold,
                  input  stall, flush_id, fwd1_sel, fwd2_sel, stall_cnt, flush_cnt);
  modport slave  (input  id, redirect, pipe_hold,
                  output stall, flush_id, fwd1_sel, fwd2_sel, stall_cnt, flush_cnt);
endinterface

// File: rtl/pipe_hazard_scoreboard_sb_entry.sv
// One tracked register: pending flag, current stage and forwardable-from latency.
module sb_entry
  import pipe_hazard_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic            set,
  input  logic [SELW-1:0] set_lat,
  output logic            pend,
  output logic [SELW-1:0] stg,
  output logic [SELW-1:0] lat
);
  logic            pend_q, pend_d;
  logic [SELW-1:0] stg_q, stg_d, lat_q, lat_d;

  // A re-issue restarts the entry even while frozen logic would advance it.
  always_comb begin
    pend_d = pend_q;
    stg_d  = stg_q;
    lat_d  = lat_q;
    if (set) begin
      pend_d = 1'b1;
      stg_d  = STG_EX;
      lat_d  = set_lat;
    end else if (adv && pend_q) begin
      if (int'(stg_q) == DEPTH) pend_d = 1'b0;
      else                      stg_d  = stg_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      stg_q  <= '0;
      lat_q  <= '0;
    end else begin
      pend_q <= pend_d;
      stg_q  <= stg_d;
      lat_q  <= lat_d;
    end
  end

  assign pend = pend_q;
  assign stg  = stg_q;
  assign lat  = lat_q;
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller: per-register stage tracking, load-use stall, bypass select, ID flush.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_hazard_scoreboard_if.slave  sb
);
  logic [NREGS-1:0]           pend;
  logic [NREGS-1:0][SELW-1:0] stg, lat;
  logic            issue, hz1, hz2, stall;
  logic [SELW-1:0] sel1, sel2, lat_fix;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign pend[0] = 1'b0;
  assign stg[0]  = '0;
  assign lat[0]  = '0;

  assign lat_fix = fix_lat(sb.id.lat);

  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    sb_entry u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (!sb.pipe_hold),
      .set     (issue && sb.id.we && sb.id.rd == RAW'(r)),
      .set_lat (lat_fix),
      .pend    (pend[r]),
      .stg     (stg[r]),
      .lat     (lat[r])
    );
  end

  // Read ports look at pre-edge state, so rd==rs sees the older producer.
  always_comb begin
    hz1  = 1'b0;
    hz2  = 1'b0;
    sel1 = FWD_REGFILE;
    sel2 = FWD_REGFILE;
    if (sb.id.rs1_used && pend[sb.id.rs1]) begin
      sel1 = stg[sb.id.rs1];
      hz1  = stg[sb.id.rs1] < lat[sb.id.rs1];
    end
    if (sb.id.rs2_used && pend[sb.id.rs2]) begin
      sel2 = stg[sb.id.rs2];
      hz2  = stg[sb.id.rs2] < lat[sb.id.rs2];
    end
  end

  assign stall = sb.pipe_hold | (sb.id.valid & ~sb.redirect & (hz1 | hz2));
  assign issue = sb.id.valid & ~stall & ~sb.redirect & ~sb.pipe_hold;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall ? CNTW'(1) : CNTW'(0));
    flush_cnt_d = flush_cnt_q + (sb.redirect ? CNTW'(1) : CNTW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.flush_id  = sb.redirect;
  assign sb.fwd1_sel  = sel1;
  assign sb.fwd2_sel  = sel2;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.flush_cnt = flush_cnt_q;

  a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (issue && sb.id.we && sb.id.rd != '0) |-> (sb.id.lat != '0 && int'(sb.id.lat) <= DEPTH));
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed checks of stall, forward select, flush and perf counters.
module tb_pipe_hazard_scoreboard;
  import pipe_hazard_scoreboard_pkg::*;

  logic clk, rst_n;
  int   n_chk, n_err;

  pipe_hazard_scoreboard_if hif();

  pipe_hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                     input int rd, input logic we, input int lat,
                     input logic redir = 1'b0, input logic hold = 1'b0);
    hif.id.valid    = v;
    hif.id.rs1      = RAW'(rs1);
    hif.id.rs1_used = u1;
    hif.id.rs2      = RAW'(rs2);
    hif.id.rs2_used = u2;
    hif.id.rd       = RAW'(rd);
    hif.id.we       = we;
    hif.id.lat      = SELW'(lat);
    hif.redirect    = redir;
    hif.pipe_hold   = hold;
  endtask

  task automatic idle();
    drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1);
  endtask

  // Inputs change just after posedge, outputs sampled at negedge.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    smp();
    chk("rst_stall", 32'(hif.stall), 0);
    chk("rst_flush", 32'(hif.flush_id), 0);
    chk("rst_sel1",  32'(hif.fwd1_sel), 0);
    chk("rst_scnt",  hif.stall_cnt, 0);
    tick();

    // ALU chain
    drv(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1); smp();
    chk("alu_p_stall", 32'(hif.stall), 0);
    tick();
    drv(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1); smp();
    chk("alu_c_stall", 32'(hif.stall), 0);
    chk("alu_c_sel1",  32'(hif.fwd1_sel), 1);
    chk("alu_c_sel2",  32'(hif.fwd2_sel), 1);
    tick();
    drv(1'b1, 5, 1'b1, 0, 1'b1, 0, 1'b0, 1); smp();
    chk("alu_c2_sel1", 32'(hif.fwd1_sel), 2);
    chk("alu_c2_sel2", 32'(hif.fwd2_sel), 0);
    tick();
    drain();

    // Load-use
    drv(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 2); smp();
    tick();
    drv(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1); smp();
    chk("ld_stall1", 32'(hif.stall), 1);
    tick();
    smp();
    chk("ld_stall2", 32'(hif.stall), 0);
    chk("ld_sel1",   32'(hif.fwd1_sel), 2);
    chk("ld_scnt",   hif.stall_cnt, 1);
    tick();
    drain();

    // Long op
    drv(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 3); smp();
    tick();
    drv(1'b1, 9, 1'b1, 0, 1'b0, 0, 1'b0, 1); smp();
    chk("long_stall_a", 32'(hif.stall), 1);
    tick(); smp();
    chk("long_stall_b", 32'(hif.stall), 1);
    tick(); smp();
    chk("long_stall_c", 32'(hif.stall), 0);
    chk("long_sel1",    32'(hif.fwd1_sel), 3);
    tick(); smp();
    chk("long_rf_sel1", 32'(hif.fwd1_sel), 0);
    chk("long_rf_stall", 32'(hif.stall), 0);
    chk("long_scnt",    hif.stall_cnt, 3);
    tick();
    drain();

    // Redirect during load-use
    drv(1'b1, 0, 1'b0, 0, 1'b0, 11, 1'b1, 2); smp();
    tick();
    drv(1'b1, 11, 1'b1, 0, 1'b0, 12, 1'b1, 1, 1'b1); smp();
    chk("rd_flush", 32'(hif.flush_id), 1);
    chk("rd_stall", 32'(hif.stall), 0);
    tick();
    drv(1'b1, 12, 1'b1, 11, 1'b1, 0, 1'b0, 1); smp();
    chk("rd_no_ent", 32'(hif.fwd1_sel), 0);
    chk("rd_old_adv", 32'(hif.fwd2_sel), 2);
    chk("rd_stall2", 32'(hif.stall), 0);
    chk("rd_fcnt",   hif.flush_cnt, 1);
    chk("rd_scnt",   hif.stall_cnt, 3);
    tick();
    drain();

    // x0 and WAW
    drv(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 2); tick();
    drv(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1); smp();
    chk("x0_sel1",  32'(hif.fwd1_sel), 0);
    chk("x0_stall", 32'(hif.stall), 0);
    tick();
    drv(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 2); tick();
    drv(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1); tick();
    drv(1'b1, 4, 1'b1, 0, 1'b0, 0, 1'b0, 1); smp();
    chk("waw_sel1",  32'(hif.fwd1_sel), 1);
    chk("waw_stall", 32'(hif.stall), 0);
    tick();
    drain();

    // Hold freezes entries
    drv(1'b1, 0, 1'b0, 0, 1'b0, 13, 1'b1, 1); tick();
    drv(1'b1, 13, 1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1); smp();
    chk("hold_stall", 32'(hif.stall), 1);
    tick();
    drv(1'b1, 13, 1'b1, 0, 1'b0, 0, 1'b0, 1); smp();
    chk("hold_frz_sel1", 32'(hif.fwd1_sel), 1);
    chk("hold_stall2",   32'(hif.stall), 0);
    chk("hold_scnt",     hif.stall_cnt, 4);
    tick();
    drain();

    // Reset mid-stream with a pending long op and a stalled consumer
    drv(1'b1, 0, 1'b0, 0, 1'b0, 14, 1'b1, 3); tick();
    drv(1'b1, 14, 1'b1, 0, 1'b0, 0, 1'b0, 1); smp();
    chk("mr_pre_stall", 32'(hif.stall), 1);
    rst_n = 1'b0;
    #2;
    chk("mr_async_scnt", hif.stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("mr_stall", 32'(hif.stall), 0);
    chk("mr_sel1",  32'(hif.fwd1_sel), 0);
    chk("mr_fcnt",  hif.flush_cnt, 0);
    tick();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
